pool_ctrl: RTL and testbench

//  Sequencer for the 2x2/stride-2 max-pool datapath (pool_max4).

---
 rtl/pool_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_pool_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/pool_ctrl.sv
// pool_ctrl - sequencer for the 2x2 / stride-2 max-pool datapath (pool_max4).
//
// Walks a multi-channel square feature map and issues one window read per
// cycle. It drives the pool unit's out_en and produces the dense write
// address and strobe for each pooled pixel. It sits between the layer
// scheduler (start/done) and the feature buffers.
//
// Parameters
//   SIZE_W  width of in_size (input map side, pixels)
//   CHAN_W  width of n_chan (channel count)
//   ADDR_W  width of read/write addresses (wraps modulo 2^ADDR_W)
//
// Ports
//   clk          clock
//   xrst         asynchronous active-low reset
//   start        one-cycle launch pulse, sampled only while idle
//   in_size      input map side S; LSB ignored (S' = S & ~1)
//   n_chan       channel count C
//   rd_en        window read strobe to the feature buffer
//   rd_addr      top-left pixel of the window (buffer fetches +0,+1,+S',+S'+1)
//   pool_en      out_en of pool_max4
//   wr_en        pooled pixel valid at pool_max4 pixel_out
//   wr_addr      dense output map address
//   busy         high from the cycle after start up to and including done
//   done         one-cycle completion pulse
//   perf_cycles  (POOL_PERF_EN only) cycles from start accepted to done
//
// Optional feature: define POOL_PERF_EN to add the perf_cycles counter.

`timescale 1ns/1ps

module pool_ctrl #(
  parameter int SIZE_W = 8,
  parameter int CHAN_W = 10,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              xrst,
  input  logic              start,
  input  logic [SIZE_W-1:0] in_size,
  input  logic [CHAN_W-1:0] n_chan,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              pool_en,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              busy,
`ifdef POOL_PERF_EN
  output logic              done,
  output logic [31:0]       perf_cycles
`else
  output logic              done
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_POOL, S_DRAIN, S_DONE} state_t;

  state_t state, nxt_state;

  logic [SIZE_W-1:0] s_even;
  logic [SIZE_W-1:0] half_in;
  logic              degen;
  logic              start_ok;

  logic [SIZE_W-1:0] half_q;
  logic [CHAN_W-1:0] chan_q;
  logic [ADDR_W-1:0] row_step_q;

  logic [SIZE_W-1:0] col;
  logic [SIZE_W-1:0] row;
  logic [CHAN_W-1:0] chan_cnt;
  logic              col_last;
  logic              row_last;
  logic              chan_last;
  logic              win_last;

  logic [ADDR_W-1:0] rd_addr_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic              v1, v2, v3;

  assign s_even   = in_size & ~SIZE_W'(1);
  assign half_in  = s_even >> 1;
  assign degen    = (half_in == '0) || (n_chan == '0);
  assign start_ok = (state == S_IDLE) && start;

  assign col_last  = (col == half_q - SIZE_W'(1));
  assign row_last  = (row == half_q - SIZE_W'(1));
  assign chan_last = (chan_cnt == chan_q - CHAN_W'(1));
  assign win_last  = col_last && row_last && chan_last;

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) state <= S_IDLE;
    else       state <= nxt_state;
  end

  // A degenerate launch passes through S_DRAIN for one cycle. The pipe is
  // already empty, so it reaches S_DONE in cycle 2, just like a run with no
  // windows would.
  always_comb begin
    nxt_state = state;
    case (state)
      S_IDLE:  if (start) nxt_state = degen ? S_DRAIN : S_POOL;
      S_POOL:  if (win_last) nxt_state = S_DRAIN;
      S_DRAIN: if (!v1 && !v2) nxt_state = S_DONE;
      S_DONE:  nxt_state = S_IDLE;
      default: nxt_state = S_IDLE;
    endcase
  end

  always_comb begin
    rd_en   = (state == S_POOL);
    busy    = (state != S_IDLE);
    done    = (state == S_DONE);
    pool_en = v2;
    wr_en   = v3;
    rd_addr = rd_addr_q;
    wr_addr = wr_addr_q;
  end

  // The row-end step 2+S' is computed once at launch, so the walk needs only
  // one adder. The same step carries the last window of a channel onto the
  // origin of the next channel (S'^2).
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      half_q     <= '0;
      chan_q     <= '0;
      row_step_q <= '0;
      col        <= '0;
      row        <= '0;
      chan_cnt   <= '0;
      rd_addr_q  <= '0;
      wr_addr_q  <= '0;
      v1         <= 1'b0;
      v2         <= 1'b0;
      v3         <= 1'b0;
    end else begin
      v1 <= rd_en;
      v2 <= v1;
      v3 <= v2;
      if (start_ok) begin
        half_q     <= half_in;
        chan_q     <= n_chan;
        row_step_q <= ADDR_W'(s_even) + ADDR_W'(2);
        col        <= '0;
        row        <= '0;
        chan_cnt   <= '0;
        rd_addr_q  <= '0;
        wr_addr_q  <= '0;
      end else begin
        if (state == S_POOL) begin
          if (col_last) begin
            col       <= '0;
            rd_addr_q <= rd_addr_q + row_step_q;
            if (row_last) begin
              row      <= '0;
              chan_cnt <= chan_cnt + CHAN_W'(1);
            end else begin
              row <= row + SIZE_W'(1);
            end
          end else begin
            col       <= col + SIZE_W'(1);
            rd_addr_q <= rd_addr_q + ADDR_W'(2);
          end
        end
        if (v3) wr_addr_q <= wr_addr_q + ADDR_W'(1);
      end
    end
  end

`ifdef POOL_PERF_EN
  // Loading 1 on launch counts the start cycle itself. The counter then
  // advances through the done cycle and saturates at all-ones.
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      perf_cycles <= '0;
    end else if (start_ok) begin
      perf_cycles <= 32'd1;
    end else if ((state != S_IDLE) && (perf_cycles != '1)) begin
      perf_cycles <= perf_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pool_ctrl.sv
// tb_pool_ctrl - self-checking bench for pool_ctrl.
// A table of runs {S, C, re-pulse cycle, window count, done cycle} is applied
// in a loop. The read and write addresses expected for each run are queued
// when start is driven, and they are popped as the DUT asserts rd_en/wr_en.
// An asynchronous-reset abort is handled by a hand-written sequence.

`timescale 1ns/1ps

module tb_pool_ctrl;

  localparam int SIZE_W = 8;
  localparam int CHAN_W = 10;
  localparam int ADDR_W = 16;

  logic              clk = 1'b0;
  logic              xrst = 1'b0;
  logic              start = 1'b0;
  logic [SIZE_W-1:0] in_size = '0;
  logic [CHAN_W-1:0] n_chan = '0;
  logic              rd_en, pool_en, wr_en, busy, done;
  logic [ADDR_W-1:0] rd_addr, wr_addr;
`ifdef POOL_PERF_EN
  logic [31:0]       perf_cycles;
`endif

  int n_vec  = 0;
  int n_miss = 0;

  logic [ADDR_W-1:0] rd_q[$];
  logic [ADDR_W-1:0] wr_q[$];

  typedef struct {
    int size;
    int chan;
    int restart_k;
    int exp_n;
    int exp_done;
  } vec_t;

  vec_t vecs[8];

  pool_ctrl #(.SIZE_W(SIZE_W), .CHAN_W(CHAN_W), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .xrst       (xrst),
    .start      (start),
    .in_size    (in_size),
    .n_chan     (n_chan),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .pool_en    (pool_en),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .busy       (busy),
`ifdef POOL_PERF_EN
    .done       (done),
    .perf_cycles(perf_cycles)
`else
    .done       (done)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Pulses start for one cycle and queues the addresses the run must produce.
  // On return the bench sits at the negative edge of cycle 1.
  task automatic applyStimulus(input int size, input int chan);
    int s2, h;
    s2 = size & ~1;
    h  = s2 / 2;
    if (s2 >= 2 && chan > 0) begin
      for (int c = 0; c < chan; c++)
        for (int r = 0; r < h; r++)
          for (int x = 0; x < h; x++) begin
            rd_q.push_back(ADDR_W'(c * s2 * s2 + 2 * r * s2 + 2 * x));
            wr_q.push_back(ADDR_W'(c * h * h + r * h + x));
          end
    end
    @(negedge clk);
    in_size = SIZE_W'(size);
    n_chan  = CHAN_W'(chan);
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    in_size = SIZE_W'($urandom_range(0, 255));
    n_chan  = CHAN_W'($urandom_range(0, 1023));
  endtask

  task automatic checkCycle(input string tag, input int k, input int n, input int dk);
    checkOutput($sformatf("%s rd_en@%0d", tag, k), rd_en, (k >= 1 && k <= n));
    if (rd_en && rd_q.size() > 0)
      checkOutput($sformatf("%s rd_addr@%0d", tag, k), rd_addr, rd_q.pop_front());
    checkOutput($sformatf("%s pool_en@%0d", tag, k), pool_en, (k >= 3 && k <= n + 2));
    checkOutput($sformatf("%s wr_en@%0d", tag, k), wr_en, (k >= 4 && k <= n + 3));
    if (wr_en && wr_q.size() > 0)
      checkOutput($sformatf("%s wr_addr@%0d", tag, k), wr_addr, wr_q.pop_front());
    checkOutput($sformatf("%s busy@%0d", tag, k), busy, (k <= dk));
    checkOutput($sformatf("%s done@%0d", tag, k), done, (k == dk));
  endtask

  task automatic runVector(input vec_t v, input string tag);
    applyStimulus(v.size, v.chan);
    for (int k = 1; k <= v.exp_done + 3; k++) begin
      if (k > 1) @(negedge clk);
      checkCycle(tag, k, v.exp_n, v.exp_done);
      start = (k + 1 == v.restart_k);
    end
    start = 1'b0;
    checkOutput($sformatf("%s rd_left", tag), rd_q.size(), 0);
    checkOutput($sformatf("%s wr_left", tag), wr_q.size(), 0);
    rd_q.delete();
    wr_q.delete();
`ifdef POOL_PERF_EN
    checkOutput($sformatf("%s perf_cycles", tag), perf_cycles, v.exp_done + 1);
`endif
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput($sformatf("%s rd_en", tag), rd_en, 0);
    checkOutput($sformatf("%s rd_addr", tag), rd_addr, 0);
    checkOutput($sformatf("%s pool_en", tag), pool_en, 0);
    checkOutput($sformatf("%s wr_en", tag), wr_en, 0);
    checkOutput($sformatf("%s wr_addr", tag), wr_addr, 0);
    checkOutput($sformatf("%s busy", tag), busy, 0);
    checkOutput($sformatf("%s done", tag), done, 0);
`ifdef POOL_PERF_EN
    checkOutput($sformatf("%s perf_cycles", tag), perf_cycles, 0);
`endif
  endtask

  initial begin
    // size, chan, start re-pulse cycle (0 = none), windows, done cycle
    vecs[0] = '{4, 1, 0, 4, 8};
    vecs[1] = '{2, 3, 0, 3, 7};
    vecs[2] = '{4, 1, 2, 4, 8};
    vecs[3] = '{5, 1, 0, 4, 8};
    vecs[4] = '{1, 1, 0, 0, 2};
    vecs[5] = '{4, 0, 0, 0, 2};
    vecs[6] = '{6, 2, 8, 18, 22};
    vecs[7] = '{8, 1, 20, 16, 20};

    xrst = 1'b0;
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    xrst = 1'b1;

    foreach (vecs[i]) runVector(vecs[i], $sformatf("vec%0d", i));

    runVector(vecs[0], "b2b");

    // Asynchronous reset during cycle 3 of an S=4, C=1 run.
    applyStimulus(4, 1);
    for (int k = 1; k <= 3; k++) begin
      if (k > 1) @(negedge clk);
      checkCycle("abort", k, 4, 8);
    end
    #2 xrst = 1'b0;
    #1 checkAllZero("abort_rst");
    @(negedge clk);
    xrst = 1'b1;
    rd_q.delete();
    wr_q.delete();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checkOutput($sformatf("abort idle_done@%0d", k), done, 0);
      checkOutput($sformatf("abort idle_busy@%0d", k), busy, 0);
      checkOutput($sformatf("abort idle_wr@%0d", k), wr_en, 0);
    end
    runVector(vecs[0], "after_abort");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
